// File: rtl/rl_pkg.sv
// rl_pkg: shared widths, FSM encoding and LFSR taps for the action selector and transition table
package rl_pkg;
  localparam int STATE_W = 3;
  localparam int ACTION_W = 2;
  localparam int N_ACTIONS = 2 ** ACTION_W;
  localparam int Q_W = 16;
  localparam int EPS_W = 8;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, COMPARE, DECIDE, OUT} fsm_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left
module lfsr16
  import rl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] lfsr
);
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  // advance every cycle, feedback enters at bit 0
  always_ff @(posedge CLK or negedge RST)
    if (!RST) lfsr <= INIT;
    else lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
endmodule

// File: rtl/action_selector.sv
// action_selector: epsilon-greedy action pick with sequential max-search, emits {state, action}
module action_selector
  import rl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [STATE_W-1:0]          state_in,
  input  logic [N_ACTIONS*Q_W-1:0]    q_vals,
  input  logic [EPS_W-1:0]            epsilon,
  output logic                        ready_out,
  output logic [STATE_W+ACTION_W-1:0] addr_out,
  output logic [ACTION_W-1:0]         action_out,
  output logic                        explore_out,
  output logic                        valid_out,
  input  logic                        out_ack
);
  fsm_t st, st_nx;
  logic [STATE_W-1:0] state_r;
  logic [N_ACTIONS*Q_W-1:0] q_r;
  logic [ACTION_W-1:0] best_idx, idx, act;
  logic signed [Q_W-1:0] best_val, cur;
  logic [15:0] lfsr;
  logic explore;
  logic unused_lfsr;

  lfsr16 #(.SEED(SEED)) u_lfsr (.CLK(CLK), .RST(RST), .lfsr(lfsr));

  assign unused_lfsr = ^lfsr;
  assign ready_out = (st == IDLE);
  assign cur = q_r[idx*Q_W +: Q_W];

  // state register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) st <= IDLE;
    else st <= st_nx;

  // next state and the explore/greedy decision from the current LFSR value
  always_comb begin
    explore = lfsr[EPS_W-1:0] < epsilon;
    act = explore ? lfsr[15 -: ACTION_W] : best_idx;
    st_nx = st == IDLE    ? (start ? COMPARE : IDLE) :
            st == COMPARE ? (idx == ACTION_W'(N_ACTIONS - 1) ? DECIDE : COMPARE) :
            st == DECIDE  ? OUT :
                            (out_ack ? IDLE : OUT);
  end

  // latch request, run one comparison per cycle, register the result
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_r <= '0;
      q_r <= '0;
      best_idx <= '0;
      best_val <= '0;
      idx <= '0;
      action_out <= '0;
      addr_out <= '0;
      explore_out <= 1'b0;
      valid_out <= 1'b0;
    end else if (st == IDLE) begin
      if (start) begin
        state_r <= state_in;
        q_r <= q_vals;
        best_idx <= '0;
        best_val <= q_vals[Q_W-1:0];
        idx <= ACTION_W'(1);
      end
    end else if (st == COMPARE) begin
      if (cur > best_val) begin
        best_val <= cur;
        best_idx <= idx;
      end
      idx <= idx + 1'b1;
    end else if (st == DECIDE) begin
      action_out <= act;
      addr_out <= {state_r, act};
      explore_out <= explore;
      valid_out <= 1'b1;
    end else if (out_ack) begin
      valid_out <= 1'b0;
    end
endmodule

// File: tb/tb_action_selector.sv
// tb_action_selector: directed and model-checked tests for action_selector
module tb_action_selector;
  import rl_pkg::*;

  logic CLK = 1'b0, RST = 1'b0, start = 1'b0, out_ack = 1'b0;
  logic [2:0] state_in = '0;
  logic [63:0] q_vals = '0;
  logic [7:0] epsilon = '0;
  logic ready_out, explore_out, valid_out;
  logic [4:0] addr_out;
  logic [1:0] action_out;
  logic [15:0] m, hw_m;
  int checks = 0, errors = 0;

  action_selector dut (
    .CLK(CLK), .RST(RST), .start(start), .state_in(state_in), .q_vals(q_vals),
    .epsilon(epsilon), .ready_out(ready_out), .addr_out(addr_out), .action_out(action_out),
    .explore_out(explore_out), .valid_out(valid_out), .out_ack(out_ack)
  );

  lfsr16 #(.SEED(16'hACE1)) u_ref (.CLK(CLK), .RST(RST), .lfsr(hw_m));

  always #5 CLK = ~CLK;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge CLK or negedge RST)
    if (!RST) m <= 16'hACE1;
    else m <= step(m);

  function automatic logic [63:0] pk(input logic [15:0] q0, q1, q2, q3);
    return {q3, q2, q1, q0};
  endfunction

  function automatic logic [1:0] greedy(input logic [63:0] q);
    logic signed [15:0] b;
    logic [1:0] bi;
    b = q[15:0];
    bi = 2'd0;
    for (int i = 1; i < 4; i++)
      if ($signed(q[i*16 +: 16]) > b) begin
        b = q[i*16 +: 16];
        bi = 2'(i);
      end
    return bi;
  endfunction

  task automatic request(input logic [2:0] s, input logic [63:0] q, input logic [7:0] e,
                         output int lat, output logic [15:0] used);
    start = 1'b1;
    state_in = s;
    q_vals = q;
    epsilon = e;
    @(posedge CLK);
    #1 start = 1'b0;
    lat = 0;
    do begin
      used = m;
      @(posedge CLK);
      #1 lat++;
    end while (!valid_out && lat < 20);
  endtask

  task automatic ack_out();
    out_ack = 1'b1;
    @(posedge CLK);
    #1 out_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks += 5;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_out); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    if (addr_out !== 5'd0) begin errors++; $display("FAIL reset_addr got %b want 0", addr_out); end
    if (action_out !== 2'd0) begin errors++; $display("FAIL reset_action got %b want 0", action_out); end
    if (explore_out !== 1'b0) begin errors++; $display("FAIL reset_explore got %b want 0", explore_out); end
    #11 RST = 1'b1;
    #1;
    checks += 2;
    if (hw_m !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr16 got %h want ace1", hw_m); end
    if (m !== 16'hACE1) begin errors++; $display("FAIL reset_model got %h want ace1", m); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_greedy();
    int lat;
    logic [15:0] used;
    request(3'b010, pk(16'd5, 16'hFFFE, 16'd40, 16'd7), 8'd0, lat, used);
    checks += 4;
    if (lat !== 4 || valid_out !== 1'b1) begin errors++; $display("FAIL greedy_latency got %0d want 4", lat); end
    if (action_out !== 2'b10) begin errors++; $display("FAIL greedy_action got %b want 10", action_out); end
    if (addr_out !== 5'b010_10) begin errors++; $display("FAIL greedy_addr got %b want 01010", addr_out); end
    if (explore_out !== 1'b0) begin errors++; $display("FAIL greedy_explore got %b want 0", explore_out); end
    ack_out();
    checks += 3;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL greedy_valid_drop got %b want 0", valid_out); end
    if (ready_out !== 1'b1) begin errors++; $display("FAIL greedy_ready got %b want 1", ready_out); end
    if (addr_out !== 5'b010_10) begin errors++; $display("FAIL greedy_addr_hold got %b want 01010", addr_out); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    start = 1'b1;
    state_in = 3'd5;
    q_vals = pk(16'd1, 16'd9, 16'd3, 16'd2);
    epsilon = 8'd0;
    @(posedge CLK);
    #1 start = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    checks += 4;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", ready_out); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", valid_out); end
    if (addr_out !== 5'd0) begin errors++; $display("FAIL mid_reset_addr got %b want 0", addr_out); end
    if (hw_m !== 16'hACE1) begin errors++; $display("FAIL mid_reset_lfsr16 got %h want ace1", hw_m); end
    #2 RST = 1'b1;
    repeat (8) begin
      @(posedge CLK);
      #1 if (valid_out) seen = 1;
    end
    checks += 2;
    if (seen) begin errors++; $display("FAIL mid_reset_emitted got 1 want 0"); end
    if (ready_out !== 1'b1) begin errors++; $display("FAIL mid_reset_idle got %b want 1", ready_out); end
  endtask

  task automatic test_ties();
    logic [63:0] qs [3];
    logic [1:0] ex [3];
    int lat;
    logic [15:0] used;
    qs[0] = pk(16'd9, 16'd9, 16'd9, 16'd9);              ex[0] = 2'd0;
    qs[1] = pk(16'h8000, 16'hFFFF, 16'h8000, 16'hFFFB);  ex[1] = 2'd1;
    qs[2] = pk(16'h8000, 16'h8000, 16'h8000, 16'h7FFF);  ex[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      request(3'd7, qs[i], 8'd0, lat, used);
      checks += 3;
      if (lat !== 4) begin errors++; $display("FAIL tie%0d_latency got %0d want 4", i, lat); end
      if (action_out !== ex[i]) begin errors++; $display("FAIL tie%0d_action got %0d want %0d", i, action_out, ex[i]); end
      if (explore_out !== 1'b0) begin errors++; $display("FAIL tie%0d_explore got %b want 0", i, explore_out); end
      ack_out();
    end
  endtask

  task automatic test_explore();
    int lat;
    logic [15:0] used;
    logic [63:0] q;
    logic [2:0] s;
    logic ex_x;
    logic [1:0] ex_a;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
      q = {$urandom, $urandom};
      s = 3'($urandom);
      request(s, q, 8'd255, lat, used);
      ex_x = used[7:0] < 8'd255;
      ex_a = ex_x ? used[15:14] : greedy(q);
      checks += 5;
      if (lat !== 4) begin errors++; $display("FAIL explore%0d_latency got %0d want 4", i, lat); end
      if (explore_out !== ex_x) begin errors++; $display("FAIL explore%0d_flag got %b want %b", i, explore_out, ex_x); end
      if (action_out !== ex_a) begin errors++; $display("FAIL explore%0d_action got %0d want %0d", i, action_out, ex_a); end
      if (addr_out !== {s, ex_a}) begin errors++; $display("FAIL explore%0d_addr got %b want %b", i, addr_out, {s, ex_a}); end
      if (hw_m !== m) begin errors++; $display("FAIL explore%0d_lfsr16 got %h want %h", i, hw_m, m); end
      ack_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] used;
    int bad = 0;
    request(3'd6, pk(16'd1, 16'd2, 16'd3, 16'd4), 8'd0, lat, used);
    checks++;
    if (lat !== 4 || addr_out !== 5'b110_11) begin errors++; $display("FAIL bp_first got lat %0d addr %b want 4 11011", lat, addr_out); end
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      state_in = 3'd1;
      q_vals = pk(16'd50, 16'd0, 16'd0, 16'd0);
      @(posedge CLK);
      #1 if (valid_out !== 1'b1 || ready_out !== 1'b0 || addr_out !== 5'b110_11 ||
             action_out !== 2'd3 || explore_out !== 1'b0) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    ack_out();
    checks += 3;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b want 0", valid_out); end
    if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready got %b want 1", ready_out); end
    if (action_out !== 2'd3) begin errors++; $display("FAIL bp_action_hold got %0d want 3", action_out); end
    @(posedge CLK);
    #1;
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL bp_not_queued got ready %b valid %b want 1 0", ready_out, valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q;
    logic [15:0] prev;
    logic ex_x;
    logic [1:0] ex_a;
    int c = 0, last = 0, n = 0;
    q = pk(16'd0, 16'd100, 16'hFF9C, 16'd50);
    state_in = 3'd4;
    q_vals = q;
    epsilon = 8'd128;
    out_ack = 1'b1;
    start = 1'b1;
    repeat (62) begin
      prev = m;
      @(posedge CLK);
      #1 c++;
      if (valid_out) begin
        ex_x = prev[7:0] < 8'd128;
        ex_a = ex_x ? prev[15:14] : 2'd1;
        checks += 3;
        if (c - last !== (n == 0 ? 5 : 6)) begin errors++; $display("FAIL b2b%0d_spacing got %0d want %0d", n, c - last, n == 0 ? 5 : 6); end
        if (explore_out !== ex_x) begin errors++; $display("FAIL b2b%0d_flag got %b want %b", n, explore_out, ex_x); end
        if (addr_out !== {3'd4, ex_a}) begin errors++; $display("FAIL b2b%0d_addr got %b want %b", n, addr_out, {3'd4, ex_a}); end
        last = c;
        n++;
      end
    end
    start = 1'b0;
    checks++;
    if (n != 10) begin errors++; $display("FAIL b2b_count got %0d want 10", n); end
    repeat (8) @(posedge CLK);
    #1 out_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_reset_mid();
    test_ties();
    test_explore();
    test_backpressure();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
